// File: rtl/pearson_msg_feeder.sv
// Message feeder for the Pearson hash core. A small FIFO buffers producer bytes.
// An FSM replays them one byte per cycle with first/last markers and leaves one
// idle cycle between messages. It also reports message length and flags
// over-length messages.
module pearson_msg_feeder #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned MAX_LEN = 255
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] byte_i,
    input  logic       byte_valid_i,
    input  logic       byte_last_i,
    output logic       byte_ready_o,
    input  logic       hash_busy_i,
    output logic [7:0] hash_byte_o,
    output logic       hash_valid_o,
    output logic       hash_first_o,
    output logic       hash_last_o,
    output logic [7:0] len_o,
    output logic       len_valid_o,
    output logic       err_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(DEPTH);
    localparam logic [8:0] MaxLen = 9'(MAX_LEN);

    typedef enum logic [1:0] {StIdle, StStream, StGap} state_e;

    state_e          state_q, state_d;
    logic [8:0]      mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic [7:0]      len_cnt_q;
    logic [7:0]      hash_byte_q, len_q;
    logic            hash_valid_q, hash_first_q, hash_last_q, len_valid_q, err_q;

    logic       full, empty, push, pop, issue_first;
    logic [7:0] rd_byte;
    logic       rd_last;
    logic [8:0] len_next;
    logic [7:0] len_sat;

    assign full         = (count_q == DepthCnt);
    assign empty        = (count_q == '0);
    assign byte_ready_o = !full;
    assign push         = byte_valid_i && byte_ready_o;
    assign rd_byte      = mem_q[rd_ptr_q][7:0];
    assign rd_last      = mem_q[rd_ptr_q][8];

    // Unsaturated next length (9 bits) so a 256th byte is still detectable.
    assign len_next = issue_first ? 9'd1 : {1'b0, len_cnt_q} + 9'd1;
    assign len_sat  = len_next[8] ? 8'hFF : len_next[7:0];

    // FIFO storage; contents are don't-care after reset since pointers clear.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {byte_last_i, byte_i};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and pop decision; pop looks only at registered occupancy.
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        issue_first = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty && !hash_busy_i) begin
                    pop         = 1'b1;
                    issue_first = 1'b1;
                    state_d     = rd_last ? StGap : StStream;
                end
            end
            StStream: begin
                if (!empty && !hash_busy_i) begin
                    pop = 1'b1;
                    if (rd_last) state_d = StGap;
                end
            end
            StGap:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Registered hash-core outputs, length counter and sticky error.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            hash_byte_q  <= 8'h00;
            hash_valid_q <= 1'b0;
            hash_first_q <= 1'b0;
            hash_last_q  <= 1'b0;
            len_cnt_q    <= 8'h00;
            len_q        <= 8'h00;
            len_valid_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            hash_valid_q <= pop;
            hash_first_q <= pop && issue_first;
            hash_last_q  <= pop && rd_last;
            len_valid_q  <= pop && rd_last;
            if (pop) begin
                hash_byte_q <= rd_byte;
                len_cnt_q   <= len_sat;
                if (rd_last)            len_q <= len_sat;
                if (len_next > MaxLen)  err_q <= 1'b1;
            end
        end
    end

    assign hash_byte_o  = hash_byte_q;
    assign hash_valid_o = hash_valid_q;
    assign hash_first_o = hash_first_q;
    assign hash_last_o  = hash_last_q;
    assign len_o        = len_q;
    assign len_valid_o  = len_valid_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_pearson_msg_feeder.sv
// Directed bench for pearson_msg_feeder: inputs driven and outputs sampled on the
// falling edge; a monitor records every issued byte for later comparison.
module tb_pearson_msg_feeder;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic [7:0] byte_i;
    logic       byte_valid_i;
    logic       byte_last_i;
    logic       byte_ready_o;
    logic       hash_busy_i;
    logic [7:0] hash_byte_o;
    logic       hash_valid_o;
    logic       hash_first_o;
    logic       hash_last_o;
    logic [7:0] len_o;
    logic       len_valid_o;
    logic       err_o;

    pearson_msg_feeder #(
        .DEPTH  (16),
        .MAX_LEN(255)
    ) u_dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .byte_i      (byte_i),
        .byte_valid_i(byte_valid_i),
        .byte_last_i (byte_last_i),
        .byte_ready_o(byte_ready_o),
        .hash_busy_i (hash_busy_i),
        .hash_byte_o (hash_byte_o),
        .hash_valid_o(hash_valid_o),
        .hash_first_o(hash_first_o),
        .hash_last_o (hash_last_o),
        .len_o       (len_o),
        .len_valid_o (len_valid_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0]  b;
        logic        first;
        logic        last;
        logic        lv;
        logic [7:0]  len;
        logic        err;
        int unsigned cyc;
    } rec_t;

    rec_t        q[$];
    int unsigned cyc = 0;
    int unsigned accept_cyc;
    int          n_checks = 0;
    int          n_errors = 0;

    // Cycle counter: value seen at a falling edge equals the number of rising edges.
    always @(posedge clk_i) cyc <= cyc + 1;

    // Record each issued byte.
    always @(negedge clk_i) begin
        if (!reset_i && hash_valid_o) begin
            q.push_back('{b: hash_byte_o, first: hash_first_o, last: hash_last_o,
                          lv: len_valid_o, len: len_o, err: err_o, cyc: cyc});
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic push(input logic [7:0] b, input logic l);
        int waits = 0;
        byte_i       = b;
        byte_last_i  = l;
        byte_valid_i = 1'b1;
        while (!byte_ready_o && waits < 200) begin
            @(negedge clk_i);
            waits++;
        end
        if (waits >= 200) check_val("push_timeout", 32'(waits), 0);
        @(negedge clk_i);
        accept_cyc   = cyc;
        byte_valid_i = 1'b0;
        byte_last_i  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    int unsigned first_acc;

    initial begin
        reset_i      = 1'b0;
        byte_i       = 8'h00;
        byte_valid_i = 1'b0;
        byte_last_i  = 1'b0;
        hash_busy_i  = 1'b0;

        // Asynchronous reset before any clock edge.
        #2 reset_i = 1'b1;
        #1;
        check_val("rst_ready", 32'(byte_ready_o), 1);
        check_val("rst_byte", 32'(hash_byte_o), 0);
        check_val("rst_valid", 32'(hash_valid_o), 0);
        check_val("rst_first", 32'(hash_first_o), 0);
        check_val("rst_last", 32'(hash_last_o), 0);
        check_val("rst_len", 32'(len_o), 0);
        check_val("rst_len_valid", 32'(len_valid_o), 0);
        check_val("rst_err", 32'(err_o), 0);
        idle(2);
        reset_i = 1'b0;
        idle(1);

        // 3-byte message.
        q.delete();
        push(8'h41, 1'b0);
        first_acc = accept_cyc;
        push(8'h42, 1'b0);
        push(8'h43, 1'b1);
        idle(5);
        check_val("m3_count", 32'(q.size()), 3);
        if (q.size() == 3) begin
            check_val("m3_b0", 32'(q[0].b), 32'h41);
            check_val("m3_b1", 32'(q[1].b), 32'h42);
            check_val("m3_b2", 32'(q[2].b), 32'h43);
            check_val("m3_first", 32'({q[0].first, q[1].first, q[2].first}), 32'b100);
            check_val("m3_last", 32'({q[0].last, q[1].last, q[2].last}), 32'b001);
            check_val("m3_lv", 32'({q[0].lv, q[1].lv, q[2].lv}), 32'b001);
            check_val("m3_len", 32'(q[2].len), 3);
            check_val("m3_latency", q[0].cyc - first_acc, 1);
            check_val("m3_span", q[2].cyc - q[0].cyc, 2);
        end

        // Back-to-back messages.
        q.delete();
        push(8'h10, 1'b1);
        push(8'h20, 1'b0);
        push(8'h21, 1'b1);
        idle(6);
        check_val("b2b_count", 32'(q.size()), 3);
        if (q.size() == 3) begin
            check_val("b2b_b0", 32'(q[0].b), 32'h10);
            check_val("b2b_fl0", 32'({q[0].first, q[0].last}), 32'b11);
            check_val("b2b_len0", 32'(q[0].len), 1);
            check_val("b2b_gap", q[1].cyc - q[0].cyc, 2);
            check_val("b2b_b1", 32'(q[1].b), 32'h20);
            check_val("b2b_fl1", 32'({q[1].first, q[1].last}), 32'b10);
            check_val("b2b_b2", 32'(q[2].b), 32'h21);
            check_val("b2b_fl2", 32'({q[2].first, q[2].last}), 32'b01);
            check_val("b2b_len2", 32'(q[2].len), 2);
            check_val("b2b_adj", q[2].cyc - q[1].cyc, 1);
        end

        // Full FIFO with the core stalled.
        q.delete();
        hash_busy_i = 1'b1;
        for (int i = 0; i < 16; i++) push(8'h80 + 8'(i), 1'b0);
        byte_i       = 8'h90;
        byte_last_i  = 1'b1;
        byte_valid_i = 1'b1;
        idle(2);
        check_val("full_ready", 32'(byte_ready_o), 0);
        check_val("stall_none", 32'(q.size()), 0);
        hash_busy_i = 1'b0;
        idle(1);
        check_val("full_ready_back", 32'(byte_ready_o), 1);
        idle(1);
        byte_valid_i = 1'b0;
        byte_last_i  = 1'b0;
        idle(25);
        check_val("full_count", 32'(q.size()), 17);
        if (q.size() == 17) begin
            for (int i = 0; i < 17; i++) check_val($sformatf("full_b%0d", i), 32'(q[i].b),
                                                   32'h80 + 32'(i));
            check_val("full_first", 32'(q[0].first), 1);
            check_val("full_last", 32'(q[16].last), 1);
            check_val("full_len", 32'(q[16].len), 17);
            check_val("full_span", q[16].cyc - q[0].cyc, 16);
        end

        // Over-length message.
        q.delete();
        for (int i = 0; i < 300; i++) push(8'(i), (i == 299));
        idle(6);
        check_val("ovl_count", 32'(q.size()), 300);
        if (q.size() == 300) begin
            for (int i = 0; i < 300; i++) begin
                if (q[i].b !== 8'(i)) check_val($sformatf("ovl_b%0d", i), 32'(q[i].b), 32'(i % 256));
            end
            check_val("ovl_b299", 32'(q[299].b), 32'h2B);
            check_val("ovl_err_255th", 32'(q[254].err), 0);
            check_val("ovl_err_256th", 32'(q[255].err), 1);
            check_val("ovl_len", 32'(q[299].len), 255);
            check_val("ovl_lv", 32'(q[299].lv), 1);
        end
        idle(3);
        check_val("ovl_err_sticky", 32'(err_o), 1);

        // Reset mid-message.
        hash_busy_i = 1'b1;
        for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i), 1'b0);
        idle(1);
        #2 reset_i = 1'b1;
        #1;
        check_val("mid_rst_err", 32'(err_o), 0);
        check_val("mid_rst_len", 32'(len_o), 0);
        check_val("mid_rst_byte", 32'(hash_byte_o), 0);
        check_val("mid_rst_ready", 32'(byte_ready_o), 1);
        @(negedge clk_i);
        reset_i     = 1'b0;
        hash_busy_i = 1'b0;
        q.delete();
        idle(1);
        push(8'h7F, 1'b1);
        idle(6);
        check_val("post_rst_count", 32'(q.size()), 1);
        if (q.size() == 1) begin
            check_val("post_rst_b", 32'(q[0].b), 32'h7F);
            check_val("post_rst_fl", 32'({q[0].first, q[0].last}), 32'b11);
            check_val("post_rst_len", 32'(q[0].len), 1);
            check_val("post_rst_lv", 32'(q[0].lv), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
